delay_line: RTL and testbench

DELAY_LINE -- requirements
Module: delay_line

---
 rtl/delay_line.sv | 86 ++++++++
 tb/tb_delay_line.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line.sv
// Tapped delay line: MAX_DELAY {valid,data} stages with a runtime-selected output tap.
// Optional occupancy counter compiled in with DELAY_LINE_OCCUPANCY_EN.
`ifndef DELAY_LINE_SV
`define DELAY_LINE_SV

module delay_line #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_DELAY = 8,
  localparam int TAP_W     = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [TAP_W-1:0] tap,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
`ifdef DELAY_LINE_OCCUPANCY_EN
  ,
  output logic [TAP_W-1:0] occupancy
`endif
);

  logic             r_valid [MAX_DELAY];
  logic [WIDTH-1:0] r_data  [MAX_DELAY];
  logic [TAP_W-1:0] w_eff_tap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_DELAY; i++) begin
        r_valid[i] <= 1'b0;
        r_data[i]  <= '0;
      end
    end else if (flush) begin
      // Flush drops only the valid bits; stale payload is harmless once invalid.
      for (int unsigned i = 0; i < MAX_DELAY; i++) r_valid[i] <= 1'b0;
    end else if (en) begin
      r_valid[0] <= in_valid;
      r_data[0]  <= in_data;
      for (int unsigned i = 1; i < MAX_DELAY; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  always_comb begin
    w_eff_tap = tap;
    if (tap == '0)
      w_eff_tap = TAP_W'(1);
    else if (tap > TAP_W'(MAX_DELAY))
      w_eff_tap = TAP_W'(MAX_DELAY);
  end

  // Compare-based mux keeps the index within the array range for any tap width.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    for (int unsigned i = 0; i < MAX_DELAY; i++) begin
      if (w_eff_tap == TAP_W'(i + 1)) begin
        out_valid = r_valid[i];
        out_data  = r_data[i];
      end
    end
  end

`ifdef DELAY_LINE_OCCUPANCY_EN
  logic [TAP_W-1:0] r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_occ <= '0;
    else if (flush)
      r_occ <= '0;
    else if (en)
      r_occ <= r_occ + TAP_W'(in_valid) - TAP_W'(r_valid[MAX_DELAY-1]);
  end

  assign occupancy = r_occ;
`endif

endmodule

`endif

// File: tb/tb_delay_line.sv
// Directed self-checking bench for delay_line (WIDTH=8, MAX_DELAY=8).
// Occupancy checks are active when DELAY_LINE_OCCUPANCY_EN is defined.
module tb_delay_line;

  localparam int WIDTH = 8;
  localparam int MAXD  = 8;
  localparam int TW    = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            flush;
  logic [TW-1:0]   tap;
  logic            in_valid;
  logic [WIDTH-1:0] in_data;
  logic            out_valid;
  logic [WIDTH-1:0] out_data;
`ifdef DELAY_LINE_OCCUPANCY_EN
  logic [TW-1:0]   occupancy;
`endif

  int errors = 0;
  int checks = 0;

  delay_line #(.WIDTH(WIDTH), .MAX_DELAY(MAXD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .flush     (flush),
    .tap       (tap),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data)
`ifdef DELAY_LINE_OCCUPANCY_EN
    ,
    .occupancy (occupancy)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; in_valid = 1'b0;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; tap = 4'd3; in_valid = 1'b0; in_data = '0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++; $display("FAIL reset_out: got v=%b d=%h want v=0 d=00", out_valid, out_data);
    end
`ifdef DELAY_LINE_OCCUPANCY_EN
    checks++;
    if (occupancy !== 4'd0) begin
      errors++; $display("FAIL reset_occ: got %0d want 0", occupancy);
    end
`endif
    #10 rst_n = 1'b1;
    step();
  endtask

  task automatic test_latency();
    tap = 4'd3;
    for (int n = 1; n <= 10; n++) begin
      in_valid = 1'b1; in_data = WIDTH'(n);
      step();
      checks++;
      if (n >= 3) begin
        if (out_valid !== 1'b1 || out_data !== WIDTH'(n - 2)) begin
          errors++; $display("FAIL latency3 edge%0d: got v=%b d=%h want v=1 d=%h", n, out_valid, out_data, WIDTH'(n - 2));
        end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("FAIL latency3 edge%0d: got v=%b want v=0", n, out_valid);
      end
    end
    do_flush();
  endtask

  task automatic test_tap_clamp();
    tap = 4'd0;
    in_valid = 1'b1; in_data = 8'h11;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      errors++; $display("FAIL tap0_out: got v=%b d=%h want v=1 d=11", out_valid, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL tap0_after: got v=%b want v=0", out_valid);
    end
    do_flush();
    tap = 4'd15;
    in_valid = 1'b1; in_data = 8'h22;
    step();
    in_valid = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      step();
      checks++;
      if (k == 8) begin
        if (out_valid !== 1'b1 || out_data !== 8'h22) begin
          errors++; $display("FAIL tap15 edge%0d: got v=%b d=%h want v=1 d=22", k, out_valid, out_data);
        end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("FAIL tap15 edge%0d: got v=%b want v=0", k, out_valid);
      end
    end
    do_flush();
  endtask

  task automatic test_hold();
    logic [WIDTH-1:0] exp_d [4];
    exp_d[0] = 8'h31; exp_d[1] = 8'h32; exp_d[2] = 8'h33; exp_d[3] = 8'h34;
    tap = 4'd8;
    for (int n = 0; n < 4; n++) begin
      in_valid = 1'b1; in_data = exp_d[n];
      step();
    end
    in_valid = 1'b0; en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k == 2); in_data = 8'hEE;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL hold_out cyc%0d: got v=%b want v=0", k, out_valid);
      end
`ifdef DELAY_LINE_OCCUPANCY_EN
      checks++;
      if (occupancy !== 4'd4) begin
        errors++; $display("FAIL hold_occ cyc%0d: got %0d want 4", k, occupancy);
      end
`endif
    end
    in_valid = 1'b0; en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (k >= 4 && k <= 7) begin
        if (out_valid !== 1'b1 || out_data !== exp_d[k-4]) begin
          errors++; $display("FAIL resume edge%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, exp_d[k-4]);
        end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("FAIL resume edge%0d: got v=%b want v=0", k, out_valid);
      end
`ifdef DELAY_LINE_OCCUPANCY_EN
      checks++;
      if (occupancy !== ((k <= 4) ? 4'd4 : TW'(8 - k))) begin
        errors++; $display("FAIL resume_occ edge%0d: got %0d want %0d", k, occupancy, (k <= 4) ? 4 : 8 - k);
      end
`endif
    end
    do_flush();
  endtask

  task automatic test_flush();
    tap = 4'd8;
    for (int n = 0; n < 5; n++) begin
      in_valid = 1'b1; in_data = WIDTH'(8'h41 + n);
      step();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h46;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_out: got v=%b want v=0", out_valid);
    end
`ifdef DELAY_LINE_OCCUPANCY_EN
    checks++;
    if (occupancy !== 4'd0) begin
      errors++; $display("FAIL flush_occ: got %0d want 0", occupancy);
    end
`endif
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_residue edge%0d: got v=%b d=%h want v=0", k, out_valid, out_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    tap = 4'd3;
    for (int n = 0; n < 8; n++) begin
      in_valid = 1'b1; in_data = WIDTH'(8'h51 + n);
      step();
    end
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      errors++; $display("FAIL midreset_out: got v=%b d=%h want v=0 d=00", out_valid, out_data);
    end
`ifdef DELAY_LINE_OCCUPANCY_EN
    checks++;
    if (occupancy !== 4'd0) begin
      errors++; $display("FAIL midreset_occ: got %0d want 0", occupancy);
    end
`endif
    #1 rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      step();
      checks++;
      if (k == 3) begin
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
          errors++; $display("FAIL postreset edge%0d: got v=%b d=%h want v=1 d=a5", k, out_valid, out_data);
        end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("FAIL postreset edge%0d: got v=%b want v=0", k, out_valid);
      end
    end
    do_flush();
  endtask

  task automatic test_saturate();
    tap = 4'd8;
    for (int k = 1; k <= 12; k++) begin
      in_valid = 1'b1; in_data = WIDTH'(k);
      step();
      checks++;
      if (k >= 8) begin
        if (out_valid !== 1'b1 || out_data !== WIDTH'(k - 7)) begin
          errors++; $display("FAIL sat_out edge%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, WIDTH'(k - 7));
        end
      end else if (out_valid !== 1'b0) begin
        errors++; $display("FAIL sat_out edge%0d: got v=%b want v=0", k, out_valid);
      end
`ifdef DELAY_LINE_OCCUPANCY_EN
      checks++;
      if (occupancy !== ((k < 8) ? TW'(k) : 4'd8)) begin
        errors++; $display("FAIL sat_occ edge%0d: got %0d want %0d", k, occupancy, (k < 8) ? k : 8);
      end
`endif
    end
    tap = 4'd2;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd11) begin
      errors++; $display("FAIL tap_change: got v=%b d=%h want v=1 d=0b", out_valid, out_data);
    end
    in_valid = 1'b0;
    do_flush();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_tap_clamp();
    test_hold();
    test_flush();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
